alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered results and flags.
// Optional macro ALU_SEQ_DIV_EN builds the restoring divider (opcodes 11 DIV, 12 MOD) and the CALC state.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             skip,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             bga,
    output logic             bea,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

`ifdef ALU_SEQ_DIV_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] y_r;
    logic             bga_r, bea_r, busy_r, done_r, dz_r;
    logic             accept_s;

    // Single-cycle result; DIV/MOD entries only apply to the divide-by-zero case.
    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
        logic [2*WIDTH-1:0] prod;
        logic               big;
        logic [SW-1:0]      sh;
        logic [WIDTH-1:0]   res;
        prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, z};
        big  = (z >= WIDTH_V);
        sh   = z[SW-1:0];
        case (op)
            4'd0:    res = x | z;
            4'd1:    res = x & z;
            4'd2:    res = x ^ z;
            4'd3:    res = x + z;
            4'd4:    res = x - z;
            4'd5:    res = big ? {WIDTH{1'b0}} : (x << sh);
            4'd6:    res = big ? {WIDTH{1'b0}} : (x >> sh);
            4'd7:    res = prod[WIDTH-1:0];
            4'd8:    res = ~x;
            4'd9:    res = big ? {WIDTH{x[WIDTH-1]}} : $unsigned($signed(x) >>> sh);
            4'd10:   res = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
            4'd11:   res = {WIDTH{1'b1}};
            4'd12:   res = x;
`endif
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    assign accept_s = (state_r == IDLE) && start;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] quot_r, rem_r, dvs_r;
    logic [CW-1:0]    cnt_r;
    logic             mod_r, pend_bga_r, pend_bea_r;
    logic             is_div_s, go_calc_s, last_s, ge_s;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic [WIDTH-1:0] rem_step_s, quot_step_s;

    assign is_div_s  = !skip && ((opcode == 4'd11) || (opcode == 4'd12));
    assign go_calc_s = is_div_s && (b != {WIDTH{1'b0}});
    assign last_s    = (cnt_r == CNT_LAST);

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        rem_sh_s    = {rem_r, quot_r[WIDTH-1]};
        diff_s      = rem_sh_s - {1'b0, dvs_r};
        ge_s        = (rem_sh_s >= {1'b0, dvs_r});
        rem_step_s  = ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
        quot_step_s = {quot_r[WIDTH-2:0], ge_s};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
`ifdef ALU_SEQ_DIV_EN
                if (start) begin
                    state_next_s = go_calc_s ? CALC : DONE;
                end else begin
                    state_next_s = IDLE;
                end
`else
                if (start) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = IDLE;
                end
`endif
            end
`ifdef ALU_SEQ_DIV_EN
            CALC: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
`endif
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Result, flag and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_r    <= {WIDTH{1'b0}};
            bga_r  <= 1'b0;
            bea_r  <= 1'b0;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            quot_r     <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            mod_r      <= 1'b0;
            pend_bga_r <= 1'b0;
            pend_bea_r <= 1'b0;
`endif
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
`ifdef ALU_SEQ_DIV_EN
            if (accept_s && go_calc_s) begin
                quot_r     <= a;
                rem_r      <= {WIDTH{1'b0}};
                dvs_r      <= b;
                cnt_r      <= {CW{1'b0}};
                mod_r      <= (opcode == 4'd12);
                pend_bga_r <= (b > a);
                pend_bea_r <= (b == a);
            end else if (accept_s) begin
                y_r   <= skip ? b : alu_f(opcode, a, b);
                bga_r <= (b > a);
                bea_r <= (b == a);
                dz_r  <= is_div_s;
            end else if (state_r == CALC) begin
                quot_r <= quot_step_s;
                rem_r  <= rem_step_s;
                cnt_r  <= cnt_r + CNT_ONE;
                if (last_s) begin
                    y_r   <= mod_r ? rem_step_s : quot_step_s;
                    bga_r <= pend_bga_r;
                    bea_r <= pend_bea_r;
                    dz_r  <= 1'b0;
                end
            end
`else
            if (accept_s) begin
                y_r   <= skip ? b : alu_f(opcode, a, b);
                bga_r <= (b > a);
                bea_r <= (b == a);
                dz_r  <= 1'b0;
            end
`endif
        end
    end

    assign y           = y_r;
    assign bga         = bga_r;
    assign bea         = bea_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dz_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances).
// Expectations follow ALU_SEQ_DIV_EN when it is defined for the build.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, skip = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] a = 32'd0, b = 32'd0, y;
    logic        bga, bea, busy, done, dz;

    logic        start8 = 1'b0, skip8 = 1'b0;
    logic [3:0]  op8 = 4'd0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0, y8;
    logic        bga8, bea8, busy8, done8, dz8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .skip(skip),
        .a(a), .b(b), .y(y), .bga(bga), .bea(bea), .busy(busy), .done(done), .div_by_zero(dz)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .opcode(op8), .skip(skip8),
        .a(a8), .b(b8), .y(y8), .bga(bga8), .bea(bea8), .busy(busy8), .done(done8), .div_by_zero(dz8)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sk;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] ey;
        logic        ebga;
        logic        ebea;
        logic        edz;
        int          elat;
    } vec_t;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [31:0] DIV_Q   = 32'd14;
    localparam logic [31:0] MOD_R   = 32'd2;
    localparam int          DIV_LAT = 33;
    localparam logic [31:0] DZ_DIV  = 32'hFFFF_FFFF;
    localparam logic [31:0] DZ_MOD  = 32'd5;
    localparam logic        DZ_FLAG = 1'b1;
`else
    localparam logic [31:0] DIV_Q   = 32'd0;
    localparam logic [31:0] MOD_R   = 32'd0;
    localparam int          DIV_LAT = 1;
    localparam logic [31:0] DZ_DIV  = 32'd0;
    localparam logic [31:0] DZ_MOD  = 32'd0;
    localparam logic        DZ_FLAG = 1'b0;
`endif

    vec_t vecs[16];

    // Issue one request; operands are scrambled after acceptance and a stray start is poked mid-run.
    task automatic run_vec(input vec_t v);
        int lat;
        int busy_cnt;
        @(negedge clk);
        opcode = v.op; skip = v.sk; a = v.av; b = v.bv; start = 1'b1;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            a = ~v.av; b = ~v.bv;
            if (lat == 5) begin
                start = 1'b1; opcode = 4'd0;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
        end while (!done && lat < 200);
        start = 1'b0;
        check_val({v.name, "_lat"}, 64'(lat), 64'(v.elat));
        check_val({v.name, "_busy"}, 64'(busy_cnt), 64'(v.elat));
        check_val({v.name, "_y"}, {32'd0, y}, {32'd0, v.ey});
        check_val({v.name, "_flags"}, {61'd0, bga, bea, dz}, {61'd0, v.ebga, v.ebea, v.edz});
    endtask

    initial begin
        vecs[0]  = '{"add_wrap", 4'd3,  1'b0, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{"shra_big", 4'd9,  1'b0, 32'h8000_0000, 32'd40,       32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{"shl_big",  4'd5,  1'b0, 32'h8000_0000, 32'd40,       32'h0000_0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{"multh",    4'd10, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{"sub",      4'd4,  1'b0, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{"xor",      4'd2,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{"shr",      4'd6,  1'b0, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{"shra4",    4'd9,  1'b0, 32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{"skip",     4'd3,  1'b1, 32'd1,         32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{"op14",     4'd14, 1'b0, 32'd9,         32'd3,        32'h0000_0000, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{"mult",     4'd7,  1'b0, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{"not",      4'd8,  1'b0, 32'h0F0F_0000, 32'd0,        32'hF0F0_FFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{"div",      4'd11, 1'b0, 32'd100,       32'd7,        DIV_Q,         1'b0, 1'b0, 1'b0, DIV_LAT};
        vecs[13] = '{"mod",      4'd12, 1'b0, 32'd100,       32'd7,        MOD_R,         1'b0, 1'b0, 1'b0, DIV_LAT};
        vecs[14] = '{"div0",     4'd11, 1'b0, 32'd5,         32'd0,        DZ_DIV,        1'b0, 1'b0, DZ_FLAG, 1};
        vecs[15] = '{"mod0",     4'd12, 1'b0, 32'd5,         32'd0,        DZ_MOD,        1'b0, 1'b0, DZ_FLAG, 1};

        #1;
        check_val("rst_outs", {26'd0, y, bga, bea, busy, done, dz, 1'b0}, 64'd0);
        check_val("rst_outs8", {50'd0, y8, bga8, bea8, busy8, done8, dz8, 1'b0}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Results hold after done; busy/done drop.
        @(negedge clk);
        check_val("hold", {30'd0, y, busy, done}, {30'd0, DZ_MOD, 1'b0, 1'b0});

        // Start held high: accepted, ignored in DONE, accepted again.
        opcode = 4'd3; skip = 1'b0; a = 32'd10; b = 32'd20; start = 1'b1;
        @(negedge clk);
        check_val("held_first", {31'd0, y, done}, {31'd0, 32'd30, 1'b1});
        @(negedge clk);
        check_val("held_gap", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check_val("held_second", {63'd0, done}, 64'd1);

        // WIDTH=8 wrap.
        @(negedge clk);
        op8 = 4'd3; a8 = 8'hF0; b8 = 8'h20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check_val("w8_add", {53'd0, y8, done8, bga8, bea8}, {53'd0, 8'h10, 1'b1, 1'b0, 1'b0});

        // Asynchronous reset in mid-request, then no stray done.
        @(negedge clk);
        opcode = 4'd11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("async_rst", {29'd0, y, busy, done, dz}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) pulses++;
            end
            check_val("no_done_after_rst", 64'(pulses), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
